// File: rtl/tran_cnt6.sv
// Six saturating per-element transition counters with common-mode normalization,
// a registered least-used-element search, and a sticky overflow flag.
module tran_cnt6 #(
   parameter int unsigned W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [5:0]     ST,
   input  logic           en,
   input  logic           clr,
   output logic [6*W-1:0] CNT,
   output logic [2:0]     MIN_IDX,
   output logic           VLD,
   output logic           OVF
);

   logic [6*W-1:0] cnt_next;
   logic           sat_hit;
   logic [2:0]     min_sel;
   logic           acc_d1;

   // Saturating increment, then subtract one from every counter when none is zero,
   // so the counters track relative usage without drifting toward saturation.
   always_comb begin
      logic [W-1:0] cur;
      logic [W-1:0] inc [6];
      logic         all_pos;
      sat_hit  = 1'b0;
      all_pos  = 1'b1;
      cnt_next = '0;
      for (int unsigned i = 0; i < 6; i++) begin
         cur = CNT[i*W +: W];
         if (ST[i] && (cur != '1)) begin
            inc[i] = cur + 1'b1;
         end else begin
            inc[i] = cur;
         end
         if (ST[i] && (cur == '1)) begin
            sat_hit = 1'b1;
         end
         if (inc[i] == '0) begin
            all_pos = 1'b0;
         end
      end
      for (int unsigned i = 0; i < 6; i++) begin
         cnt_next[i*W +: W] = all_pos ? (inc[i] - 1'b1) : inc[i];
      end
   end

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      logic [W-1:0] min_val;
      min_val = CNT[0 +: W];
      min_sel = '0;
      for (int unsigned i = 1; i < 6; i++) begin
         if (CNT[i*W +: W] < min_val) begin
            min_val = CNT[i*W +: W];
            min_sel = 3'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         CNT     <= '0;
         OVF     <= 1'b0;
         MIN_IDX <= '0;
         VLD     <= 1'b0;
         acc_d1  <= 1'b0;
      end else if (clr) begin
         CNT     <= '0;
         OVF     <= 1'b0;
         MIN_IDX <= '0;
         VLD     <= 1'b0;
         acc_d1  <= 1'b0;
      end else begin
         acc_d1  <= en;
         VLD     <= acc_d1;
         MIN_IDX <= min_sel;
         if (en) begin
            CNT <= cnt_next;
            OVF <= OVF | sat_hit;
         end
      end
   end

endmodule

// File: tb/tb_tran_cnt6.sv
// Bench for tran_cnt6: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an array-based usage model.
module tb_tran_cnt6;
   localparam int W    = 8;
   localparam int MAXV = (1 << W) - 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [5:0]     ST;
   logic           en;
   logic           clr;
   logic [6*W-1:0] CNT;
   logic [2:0]     MIN_IDX;
   logic           VLD;
   logic           OVF;

   int checks = 0;
   int errors = 0;

   int m_cnt [6];
   int m_min;
   bit m_ovf;
   bit m_vld;
   bit m_pipe [$];
   bit cmp_on = 1'b0;

   tran_cnt6 #(.W(W)) dut (
      .clk(clk), .rst(rst), .ST(ST), .en(en), .clr(clr),
      .CNT(CNT), .MIN_IDX(MIN_IDX), .VLD(VLD), .OVF(OVF)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic lit_cnt(input int i, input int v);
      chk($sformatf("lit_cnt%0d", i), 32'(CNT[i*W +: W]), v);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
      m_min = 0;
      m_ovf = 1'b0;
      m_vld = 1'b0;
      m_pipe = {};
      m_pipe.push_back(1'b0);
   endtask

   // One clock edge of the usage model: MIN_IDX reflects counts before this edge,
   // VLD reflects acceptance two edges ago.
   task automatic model_edge();
      int newmin;
      int inc [6];
      int lo;
      newmin = 0;
      for (int i = 1; i < 6; i++) if (m_cnt[i] < m_cnt[newmin]) newmin = i;
      m_vld = m_pipe.pop_front();
      m_pipe.push_back(en && !clr);
      if (clr) begin
         for (int i = 0; i < 6; i++) m_cnt[i] = 0;
         m_ovf = 1'b0;
         m_min = 0;
         m_vld = 1'b0;
      end else begin
         m_min = newmin;
         if (en) begin
            lo = MAXV;
            for (int i = 0; i < 6; i++) begin
               inc[i] = m_cnt[i] + int'(ST[i]);
               if (inc[i] > MAXV) begin
                  inc[i] = MAXV;
                  m_ovf = 1'b1;
               end
               if (inc[i] < lo) lo = inc[i];
            end
            for (int i = 0; i < 6; i++) m_cnt[i] = (lo >= 1) ? inc[i] - 1 : inc[i];
         end
      end
   endtask

   task automatic step(input logic [5:0] st, input logic e, input logic c);
      ST = st; en = e; clr = c;
      @(posedge clk);
      #1 model_edge();
   endtask

   task automatic reset_checks(input string tag);
      for (int i = 0; i < 6; i++) lit_cnt(i, 0);
      chk({tag, "_min"}, 32'(MIN_IDX), 0);
      chk({tag, "_vld"}, 32'(VLD), 0);
      chk({tag, "_ovf"}, 32'(OVF), 0);
   endtask

   // Reset asserted between edges with random inputs; outputs must clear immediately.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      ST  = 6'($urandom);
      en  = 1'($urandom);
      clr = 1'b0;
      #1 model_reset();
      reset_checks("rst_async");
      @(posedge clk);
      #1 reset_checks("rst_held");
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         for (int i = 0; i < 6; i++)
            chk($sformatf("cnt%0d", i), 32'(CNT[i*W +: W]), m_cnt[i]);
         chk("min_idx", 32'(MIN_IDX), m_min);
         chk("vld", 32'(VLD), 32'(m_vld));
         chk("ovf", 32'(OVF), 32'(m_ovf));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; ST = '0; en = 1'b0; clr = 1'b0;
      model_reset();
      do_reset();
      cmp_on = 1'b1;

      // Single element counted three times.
      step(6'b000001, 1'b1, 1'b0);
      lit_cnt(0, 1);
      chk("single_vld_early", 32'(VLD), 0);
      step(6'b000001, 1'b1, 1'b0);
      chk("single_min", 32'(MIN_IDX), 1);
      chk("single_vld", 32'(VLD), 1);
      step(6'b000001, 1'b1, 1'b0);
      lit_cnt(0, 3);
      lit_cnt(5, 0);

      // Normalization preserves differences.
      do_reset();
      step(6'b100000, 1'b1, 1'b0);
      step(6'b100000, 1'b1, 1'b0);
      lit_cnt(5, 2);
      step(6'b111111, 1'b1, 1'b0);
      lit_cnt(5, 2);
      lit_cnt(0, 0);
      step(6'b011111, 1'b1, 1'b0);
      lit_cnt(5, 1);
      lit_cnt(0, 0);
      lit_cnt(4, 0);

      // Enable gating and tie-break to the lowest index.
      do_reset();
      step(6'b101011, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) step(6'b111111, 1'b0, 1'b0);
      lit_cnt(0, 1);
      lit_cnt(2, 0);
      lit_cnt(5, 1);
      chk("gate_vld", 32'(VLD), 0);
      chk("tie_min", 32'(MIN_IDX), 2);

      // Saturation of element 0.
      do_reset();
      for (int k = 1; k <= 300; k++) begin
         step(6'b000001, 1'b1, 1'b0);
         if (k == 255) begin
            lit_cnt(0, 255);
            chk("sat_ovf_before", 32'(OVF), 0);
         end
         if (k == 256) begin
            lit_cnt(0, 255);
            chk("sat_ovf_after", 32'(OVF), 1);
         end
      end
      lit_cnt(0, 255);
      lit_cnt(1, 0);
      chk("sat_ovf_hold", 32'(OVF), 1);

      // Clear wins over enable.
      step(6'b111111, 1'b1, 1'b1);
      lit_cnt(0, 0);
      lit_cnt(3, 0);
      chk("clr_ovf", 32'(OVF), 0);
      chk("clr_vld", 32'(VLD), 0);

      // Reset mid-stream discards in-flight samples; first sample after counts.
      for (int k = 0; k < 5; k++) step(6'($urandom), 1'b1, 1'b0);
      do_reset();
      step(6'b000010, 1'b1, 1'b0);
      lit_cnt(1, 1);
      lit_cnt(0, 0);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         step(6'($urandom), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 39) == 0));
      end

      // Biased traffic driving element 3 into saturation with sparse others.
      step(6'b000000, 1'b1, 1'b1);
      for (int k = 0; k < 600; k++) begin
         step(6'b001000 | (($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'b0),
              1'($urandom_range(0, 9) != 0), 1'b0);
      end

      cmp_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
